// File: rtl/foreground_sequencer.sv
// foreground_sequencer
//   Match-flow controller for the full-screen foreground overlay. Steps through the
//   title, round banner, fight, KO banner and winner screens. It drives the overlay
//   enable, the image select and the base read address into the shared foreground
//   image RAM. Banner durations are counted in vertical frames taken from frame_clk.
//
// Optional feature (compile-time macro FOREGROUND_AUTOSTART_EN):
//   When defined, the title screen leaves for the first round after TITLE_FRAMES
//   frames. The winner screen returns to the title after TITLE_FRAMES frames. The
//   start key still works in both states. When undefined, both screens wait for start.
//
// Ports:
//   Clk              in   system clock
//   Reset            in   asynchronous active-low reset
//   frame_clk        in   vertical-sync frame clock, asynchronous to Clk
//   start            in   start key level (rising edge acts)
//   ko_p1, ko_p2     in   player health reached zero (level)
//   exist_foreground out  overlay enable
//   image_sel        out  0=title 1=round 2=KO 3=winner
//   base_address     out  image_sel * IMG_WORDS
//   fight_active     out  high only while fighting
//   round_num        out  current round, 1..3 (0 before first match)
//   wins_p1, wins_p2 out  round wins per player (saturate at 3)
//   winner           out  0=none/draw 1=p1 2=p2, valid on the winner screen
module foreground_sequencer #(
    parameter int unsigned ROUND_FRAMES  = 120,
    parameter int unsigned KO_FRAMES     = 180,
    parameter int unsigned ROUNDS_TO_WIN = 2,
    parameter int unsigned IMG_WORDS     = 76800,
    parameter int unsigned TITLE_FRAMES  = 300
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start,
    input  logic        ko_p1,
    input  logic        ko_p2,
    output logic        exist_foreground,
    output logic [1:0]  image_sel,
    output logic [18:0] base_address,
    output logic        fight_active,
    output logic [1:0]  round_num,
    output logic [1:0]  wins_p1,
    output logic [1:0]  wins_p2,
    output logic [1:0]  winner
);

    typedef enum logic [2:0] {
        StTitle,
        StRound,
        StFight,
        StKo,
        StWin
    } state_e;

    localparam logic [8:0] ROUND_LAST = 9'(ROUND_FRAMES - 1);
    localparam logic [8:0] KO_LAST    = 9'(KO_FRAMES - 1);
    localparam logic [1:0] WIN_TARGET = 2'(ROUNDS_TO_WIN);

    state_e     state;
    logic [8:0] frame_cnt;
    logic       frame_sync1;
    logic       frame_sync2;
    logic       frame_prev;
    logic       start_prev;
    logic       frame_tick;
    logic       start_pulse;
    logic       title_timeout;

    assign frame_tick  = frame_sync2 & ~frame_prev;
    assign start_pulse = start & ~start_prev;

`ifdef FOREGROUND_AUTOSTART_EN
    localparam logic [8:0] TITLE_LAST = 9'(TITLE_FRAMES - 1);
    assign title_timeout = frame_tick && (frame_cnt == TITLE_LAST);
`else
    logic unused_title_frames;
    assign unused_title_frames = ^32'(TITLE_FRAMES);
    assign title_timeout       = 1'b0;
`endif

    function automatic logic [18:0] base_of(input logic [1:0] sel);
        return 19'(32'(sel) * IMG_WORDS);
    endfunction

    function automatic logic [1:0] sat_inc(input logic [1:0] w);
        return (w == 2'd3) ? w : w + 2'd1;
    endfunction

    // frame_clk crosses into Clk through two flops before edge detection.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_sync1 <= 1'b0;
            frame_sync2 <= 1'b0;
            frame_prev  <= 1'b0;
            start_prev  <= 1'b0;
        end else begin
            frame_sync1 <= frame_clk;
            frame_sync2 <= frame_sync1;
            frame_prev  <= frame_sync2;
            start_prev  <= start;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state            <= StTitle;
            frame_cnt        <= 9'd0;
            exist_foreground <= 1'b1;
            image_sel        <= 2'd0;
            base_address     <= 19'd0;
            fight_active     <= 1'b0;
            round_num        <= 2'd0;
            wins_p1          <= 2'd0;
            wins_p2          <= 2'd0;
            winner           <= 2'd0;
        end else begin
            // Every transition below clears the counter. A tick on the same edge
            // is therefore dropped rather than counted in the new state.
            if (frame_tick) begin
                frame_cnt <= frame_cnt + 9'd1;
            end

            unique case (state)
                StTitle: begin
                    if (start_pulse || title_timeout) begin
                        state            <= StRound;
                        frame_cnt        <= 9'd0;
                        exist_foreground <= 1'b1;
                        image_sel        <= 2'd1;
                        base_address     <= base_of(2'd1);
                        round_num        <= 2'd1;
                        wins_p1          <= 2'd0;
                        wins_p2          <= 2'd0;
                        winner           <= 2'd0;
                    end
                end

                StRound: begin
                    if (frame_tick && (frame_cnt == ROUND_LAST)) begin
                        state            <= StFight;
                        frame_cnt        <= 9'd0;
                        exist_foreground <= 1'b0;
                        fight_active     <= 1'b1;
                    end
                end

                StFight: begin
                    if (ko_p1 || ko_p2) begin
                        state            <= StKo;
                        frame_cnt        <= 9'd0;
                        exist_foreground <= 1'b1;
                        image_sel        <= 2'd2;
                        base_address     <= base_of(2'd2);
                        fight_active     <= 1'b0;
                        // A simultaneous double KO is a draw and credits nobody.
                        if (ko_p1 && !ko_p2) begin
                            wins_p2 <= sat_inc(wins_p2);
                        end else if (ko_p2 && !ko_p1) begin
                            wins_p1 <= sat_inc(wins_p1);
                        end
                    end
                end

                StKo: begin
                    if (frame_tick && (frame_cnt == KO_LAST)) begin
                        frame_cnt <= 9'd0;
                        if ((wins_p1 >= WIN_TARGET) || (wins_p2 >= WIN_TARGET) ||
                            (round_num == 2'd3)) begin
                            state        <= StWin;
                            image_sel    <= 2'd3;
                            base_address <= base_of(2'd3);
                            if (wins_p1 > wins_p2) begin
                                winner <= 2'd1;
                            end else if (wins_p2 > wins_p1) begin
                                winner <= 2'd2;
                            end else begin
                                winner <= 2'd0;
                            end
                        end else begin
                            state        <= StRound;
                            image_sel    <= 2'd1;
                            base_address <= base_of(2'd1);
                            round_num    <= round_num + 2'd1;
                        end
                    end
                end

                StWin: begin
                    // The title screen shows a clean slate, matching the reset state.
                    if (start_pulse || title_timeout) begin
                        state        <= StTitle;
                        frame_cnt    <= 9'd0;
                        image_sel    <= 2'd0;
                        base_address <= 19'd0;
                        round_num    <= 2'd0;
                        wins_p1      <= 2'd0;
                        wins_p2      <= 2'd0;
                        winner       <= 2'd0;
                    end
                end

                default: begin
                    state            <= StTitle;
                    frame_cnt        <= 9'd0;
                    exist_foreground <= 1'b1;
                    image_sel        <= 2'd0;
                    base_address     <= 19'd0;
                    fight_active     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_foreground_sequencer.sv
// Scoreboard bench for foreground_sequencer. The stimulus pushes the expected output
// snapshot for each screen change it provokes. A monitor pops one entry and compares
// it whenever the observable outputs change. Extra direct checks cover "not yet"
// conditions and the asynchronous reset.
module tb_foreground_sequencer;

    typedef struct packed {
        logic        exist;
        logic [1:0]  sel;
        logic [18:0] base;
        logic        fight;
        logic [1:0]  round;
        logic [1:0]  w1;
        logic [1:0]  w2;
        logic [1:0]  win;
    } snap_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        start = 1'b0;
    logic        ko_p1 = 1'b0;
    logic        ko_p2 = 1'b0;
    logic        exist_foreground;
    logic [1:0]  image_sel;
    logic [18:0] base_address;
    logic        fight_active;
    logic [1:0]  round_num;
    logic [1:0]  wins_p1;
    logic [1:0]  wins_p2;
    logic [1:0]  winner;

    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    snap_t exp_q[$];

    foreground_sequencer #(
        .ROUND_FRAMES (4),
        .KO_FRAMES    (3),
        .ROUNDS_TO_WIN(2)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .frame_clk       (frame_clk),
        .start           (start),
        .ko_p1           (ko_p1),
        .ko_p2           (ko_p2),
        .exist_foreground(exist_foreground),
        .image_sel       (image_sel),
        .base_address    (base_address),
        .fight_active    (fight_active),
        .round_num       (round_num),
        .wins_p1         (wins_p1),
        .wins_p2         (wins_p2),
        .winner          (winner)
    );

    always #5 Clk = ~Clk;

    // Hand-computed base addresses for 320x240 images (76800 words each).
    function automatic snap_t mk(input logic e, input logic [1:0] s, input logic f,
                                 input logic [1:0] r, input logic [1:0] a,
                                 input logic [1:0] b, input logic [1:0] w);
        snap_t t;
        t.exist = e;
        t.sel   = s;
        case (s)
            2'd0:    t.base = 19'd0;
            2'd1:    t.base = 19'd76800;
            2'd2:    t.base = 19'd153600;
            default: t.base = 19'd230400;
        endcase
        t.fight = f;
        t.round = r;
        t.w1    = a;
        t.w2    = b;
        t.win   = w;
        return t;
    endfunction

    function automatic snap_t cur_snap();
        snap_t t;
        t.exist = exist_foreground;
        t.sel   = image_sel;
        t.base  = base_address;
        t.fight = fight_active;
        t.round = round_num;
        t.w1    = wins_p1;
        t.w2    = wins_p2;
        t.win   = winner;
        return t;
    endfunction

    task automatic expect_now(input string name, input snap_t want);
        snap_t got;
        got = cur_snap();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge Clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout pending %0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            frame_clk = 1'b1;
            repeat (4) @(negedge Clk);
            frame_clk = 1'b0;
            repeat (4) @(negedge Clk);
        end
    endtask

    task automatic press_start();
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
    endtask

    task automatic ko(input logic a, input logic b);
        @(negedge Clk);
        ko_p1 = a;
        ko_p2 = b;
        @(negedge Clk);
        ko_p1 = 1'b0;
        ko_p2 = 1'b0;
        @(negedge Clk);
    endtask

    // Monitor: every change of the output snapshot consumes one expectation.
    initial begin
        snap_t prev;
        snap_t cur;
        snap_t want;
        prev = mk(1, 0, 0, 0, 0, 0, 0);
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                cur = cur_snap();
                if (cur !== prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change got %h prev %h", cur, prev);
                    end else begin
                        want = exp_q.pop_front();
                        if (cur !== want) begin
                            errors++;
                            $display("FAIL scoreboard got %h want %h", cur, want);
                        end
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        snap_t title0;
        snap_t r1;
        snap_t f1;
        title0 = mk(1, 0, 0, 0, 0, 0, 0);
        r1     = mk(1, 1, 0, 1, 0, 0, 0);
        f1     = mk(0, 1, 1, 1, 0, 0, 0);

        // 1: reset and idle title
        #1 Reset = 1'b0;
        repeat (5) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        mon_en = 1'b1;
        expect_now("reset_state", title0);
        ticks(10);
        expect_now("title_idle", title0);

        // 2: start -> round 1 -> fight after 4 ticks
        exp_q.push_back(r1);
        press_start();
        wait_drain("to_round1");
        press_start();  // start outside TITLE/WIN is ignored
        exp_q.push_back(f1);
        ticks(3);
        expect_now("round1_hold", r1);
        ticks(1);
        wait_drain("to_fight1");

        // 3: p1 KO -> p2 scores, round 2 after 3 ticks
        exp_q.push_back(mk(1, 2, 0, 1, 0, 1, 0));
        ko(1, 0);
        wait_drain("ko_p1_r1");
        exp_q.push_back(mk(1, 1, 0, 2, 0, 1, 0));
        ticks(2);
        expect_now("ko_hold", mk(1, 2, 0, 1, 0, 1, 0));
        ticks(1);
        wait_drain("to_round2");
        ko(0, 1);  // KO flags ignored outside FIGHT
        exp_q.push_back(mk(0, 1, 1, 2, 0, 1, 0));
        ticks(4);
        wait_drain("to_fight2");

        // 4: draw, round 3, p1 scores, 1-1 at round 3 -> draw winner
        exp_q.push_back(mk(1, 2, 0, 2, 0, 1, 0));
        ko(1, 1);
        wait_drain("ko_draw");
        exp_q.push_back(mk(1, 1, 0, 3, 0, 1, 0));
        ticks(3);
        wait_drain("to_round3");
        exp_q.push_back(mk(0, 1, 1, 3, 0, 1, 0));
        ticks(4);
        wait_drain("to_fight3");
        exp_q.push_back(mk(1, 2, 0, 3, 1, 1, 0));
        ko(0, 1);
        wait_drain("ko_p2_r3");
        exp_q.push_back(mk(1, 3, 0, 3, 1, 1, 0));
        ticks(3);
        wait_drain("to_win_draw");
        ticks(4);
        expect_now("win_idle", mk(1, 3, 0, 3, 1, 1, 0));

        // 5: back to title, new match, p2 wins two straight
        exp_q.push_back(title0);
        press_start();
        wait_drain("win_to_title");
        exp_q.push_back(r1);
        press_start();
        wait_drain("m2_round1");
        exp_q.push_back(f1);
        ticks(4);
        wait_drain("m2_fight1");
        exp_q.push_back(mk(1, 2, 0, 1, 0, 1, 0));
        ko(1, 0);
        wait_drain("m2_ko1");
        exp_q.push_back(mk(1, 1, 0, 2, 0, 1, 0));
        ticks(3);
        wait_drain("m2_round2");
        exp_q.push_back(mk(0, 1, 1, 2, 0, 1, 0));
        ticks(4);
        wait_drain("m2_fight2");
        exp_q.push_back(mk(1, 2, 0, 2, 0, 2, 0));
        ko(1, 0);
        wait_drain("m2_ko2");
        exp_q.push_back(mk(1, 3, 0, 2, 0, 2, 2));
        ticks(3);
        wait_drain("m2_win_p2");
        exp_q.push_back(title0);
        press_start();
        wait_drain("m2_to_title");

        // 6: async reset mid-fight, then a tick coinciding with a transition
        exp_q.push_back(r1);
        press_start();
        wait_drain("m3_round1");
        exp_q.push_back(f1);
        ticks(4);
        wait_drain("m3_fight1");
        @(negedge Clk);
        #2;
        exp_q.push_back(title0);
        Reset = 1'b0;
        #1;
        expect_now("async_reset", title0);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        wait_drain("reset_seen");

        exp_q.push_back(r1);
        @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        start = 1'b1;   // start_pulse lands on the same edge as frame_tick
        @(negedge Clk);
        start = 1'b0;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        wait_drain("coincident_round1");
        exp_q.push_back(f1);
        ticks(3);
        expect_now("coincident_hold", r1);
        ticks(1);
        wait_drain("coincident_fight");

        repeat (5) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/foreground_sequencer.md
Name: foreground_sequencer

Overview:
Match-flow controller for the full-screen foreground overlay layer.
- Sequences the title, round-banner, fight, KO and winner screens.
- Drives the overlay enable, the image select and the base read address into the shared foreground image RAM.
- Counts vertical frames from frame_clk to time the banners.
- Sits between game logic (start key, player KO flags) and the foreground pixel reader in the colour mapper path.

Parameters:
ROUND_FRAMES, 120, frames the round banner is shown (1..511)
KO_FRAMES, 180, frames the KO banner is shown (1..511)
ROUNDS_TO_WIN, 2, round wins needed to end the match (1..3)
IMG_WORDS, 76800, words per stored 320x240 image; base_address = image_sel*IMG_WORDS
TITLE_FRAMES, 300, autostart delay, used only with the optional feature (1..511)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
frame_clk  in  1  vertical-sync frame clock, asynchronous to Clk
start  in  1  start key level; rising edge acts
ko_p1  in  1  level: player 1 health reached zero
ko_p2  in  1  level: player 2 health reached zero
exist_foreground  out  1  overlay enable to the foreground layer
image_sel  out  2  0=title 1=round 2=KO 3=winner
base_address  out  19  image base offset into the foreground RAM
fight_active  out  1  high only in FIGHT; gates player control
round_num  out  2  current round, 1..3
wins_p1  out  2  round wins, player 1
wins_p2  out  2  round wins, player 2
winner  out  2  0=none/draw 1=p1 2=p2; valid in WIN

Behaviour:
- Reset (Reset=0, async): state TITLE, exist_foreground=1, image_sel=0, base_address=0, fight_active=0, round_num=0, wins=0, winner=0, frame counter=0, synchronisers cleared.
- frame_clk: 2-flop synchroniser, then rising-edge detect, giving a 1-Clk frame_tick. start: rising-edge detect, giving start_pulse.
- All outputs are registered. base_address updates on the same edge as image_sel.
- Frame counter: 9 bits, cleared on every state entry, incremented on frame_tick.
- TITLE: start_pulse -> ROUND. On entry round_num=1, wins=0, winner=0.
- ROUND: exist=1, sel=1. On frame_tick with count==ROUND_FRAMES-1 -> FIGHT.
- FIGHT: exist=0, fight_active=1. KO flags are sampled every Clk:
  - ko_p1 only: wins_p2+1, go to KO.
  - ko_p2 only: wins_p1+1, go to KO.
  - Both in the same cycle: draw, no increment, go to KO.
  - Flags are ignored in all other states.
- KO: exist=1, sel=2. On frame_tick with count==KO_FRAMES-1:
  - If wins_p1==ROUNDS_TO_WIN or wins_p2==ROUNDS_TO_WIN, or round_num==3: go to WIN. winner = player with more wins; 0 on a tie.
  - Otherwise go to ROUND with round_num+1.
- WIN: exist=1, sel=3. start_pulse -> TITLE.
- start_pulse outside TITLE and WIN is ignored.
- A frame_tick and a state transition on the same Clk: the counter clears; the tick is not counted in the new state.
- Win counters saturate at 3. round_num never exceeds 3.
- Reset mid-match returns to TITLE within the same cycle (async). No output glitches after the first Clk edge once reset is released.

Optional Feature:
FOREGROUND_AUTOSTART_EN
- Defined: TITLE also exits to ROUND on frame_tick when count==TITLE_FRAMES-1. WIN returns to TITLE after TITLE_FRAMES frames. start still works in both states.
- Undefined: TITLE and WIN wait for start only. TITLE_FRAMES is unused.

Test Plan:
Parameters for all scenarios: ROUND_FRAMES=4, KO_FRAMES=3, ROUNDS_TO_WIN=2.
1. Reset held low for 5 Clk, then release -> exist=1, sel=0, base=0, round_num=0, fight_active=0. Unchanged after 10 frame_ticks (macro off).
2. start rises -> next Clk: sel=1, base=76800, round_num=1. After 4 frame_ticks -> exist=0, fight_active=1.
3. In FIGHT, pulse ko_p1 for 1 Clk -> wins_p2=1, sel=2, base=153600. After 3 ticks -> sel=1, round_num=2.
4. ko_p1 and ko_p2 high in the same cycle -> wins unchanged. After KO -> round 3. Then ko_p2 -> wins_p1=1. With wins 1-1 at round 3 -> WIN, sel=3, base=230400, winner=0.
5. p2 wins rounds 1 and 2 -> WIN after the second KO, winner=2, round_num=2. start -> TITLE, sel=0.
6. Reset asserted mid-FIGHT -> exist=1, sel=0, fight_active=0 immediately, without waiting for a Clk edge. frame_clk toggling at the same time as a state change causes no extra count.
